// File: rtl/serial_deshifter_if.sv
// Serial-in / parallel-out bundle for serial_deshifter.
// Serial side: Sin, SinValid, Start, Dir.
// Word side: DOut, DValid, DReady, Overrun, ParErr.
// The slave modport is the deshifter.
// The master modport is its environment.
interface serial_deshifter_if #(
    parameter int WIDTH = 4
);
    logic             Sin;
    logic             SinValid;
    logic             Start;
    logic             Dir;
    logic [WIDTH-1:0] DOut;
    logic             DValid;
    logic             DReady;
    logic             Overrun;
    logic             ParErr;

    modport slave (
        input  Sin, SinValid, Start, Dir, DReady,
        output DOut, DValid, Overrun, ParErr
    );

    modport master (
        output Sin, SinValid, Start, Dir, DReady,
        input  DOut, DValid, Overrun, ParErr
    );
endinterface

// File: rtl/serial_deshifter.sv
// Serial deshifter: reassembles WIDTH-bit frames into parallel words.
// Words are held in a one-entry valid/ready output buffer.
// Ports: Clk, Rst (async, active low), bus (serial_deshifter_if.slave).
// Option: PARITY_CHK_EN adds a trailing even-parity bit per frame.
// PARITY_CHK_EN also drives ParErr. Without it, ParErr is tied to 0.
module serial_deshifter #(
    parameter int WIDTH = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    serial_deshifter_if.slave  bus
);
`ifdef PARITY_CHK_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = $clog2(FLEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FLEN);
    localparam logic [CW-1:0] DLEN = CW'(WIDTH);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_inc;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_nxt;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_word;
    logic             r_dir;
    logic             w_dir;
    logic             r_dvalid;
    logic             r_ovr;
    logic             w_take;
    logic             w_data;
    logic             w_done;
    logic             w_load;
    logic             w_drop;
`ifdef PARITY_CHK_EN
    logic             r_par;
    logic             r_perr;
`endif

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.SinValid) begin
            if (bus.Start)
                w_state_nxt = S_SHIFT;
            else if (r_state == S_SHIFT && w_cnt_inc == LAST)
                w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        w_take   = bus.SinValid & (bus.Start | (r_state == S_SHIFT));
        w_dir    = bus.Start ? bus.Dir : r_dir;
        w_done   = w_take & ~bus.Start & (w_cnt_inc == LAST);
        // with parity on, the trailing bit is checked but not shifted
        w_data   = bus.Start | (r_cnt < DLEN);
        w_sh_nxt = w_dir ? {bus.Sin, r_sh[WIDTH-1:1]}
                         : {r_sh[WIDTH-2:0], bus.Sin};
`ifdef PARITY_CHK_EN
        w_word   = r_sh;
`else
        w_word   = w_sh_nxt;
`endif
        w_load   = w_done & (~r_dvalid | bus.DReady);
        w_drop   = w_done & r_dvalid & ~bus.DReady;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt    <= '0;
            r_sh     <= '0;
            r_dir    <= 1'b0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
            r_ovr    <= 1'b0;
`ifdef PARITY_CHK_EN
            r_par    <= 1'b0;
            r_perr   <= 1'b0;
`endif
        end else begin
            if (w_take) begin
                r_cnt <= w_done ? '0 : (bus.Start ? CW'(1) : w_cnt_inc);
                r_dir <= w_dir;
                if (w_data) r_sh <= w_sh_nxt;
`ifdef PARITY_CHK_EN
                r_par <= bus.Start ? bus.Sin : (r_par ^ bus.Sin);
`endif
            end
            if (w_load) begin
                r_dout   <= w_word;
                r_dvalid <= 1'b1;
`ifdef PARITY_CHK_EN
                r_perr   <= r_par ^ bus.Sin;
`endif
            end else if (r_dvalid && bus.DReady) begin
                r_dvalid <= 1'b0;
            end
            r_ovr <= w_drop;
        end
    end

    assign bus.DOut    = r_dout;
    assign bus.DValid  = r_dvalid;
    assign bus.Overrun = r_ovr;
`ifdef PARITY_CHK_EN
    assign bus.ParErr  = r_perr;
`else
    assign bus.ParErr  = 1'b0;
`endif
endmodule

// File: doc/serial_deshifter.md
Name: serial_deshifter

Overview:
- Receive end of the team's 4-bit serial shift path: collects bits shifted one per qualified cycle and reassembles them into a parallel word.
- Bit order per frame is selectable: shift-left (first bit lands in MSB) or shift-right (first bit lands in LSB), mirroring the shifter's left/right modes.
- Completed words go to a one-entry output buffer with a valid/ready handshake toward the datapath.

Parameters:
WIDTH, 4, data bits per frame (WIDTH >= 2)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst  input  1  asynchronous, active-low reset (Rst=0 resets immediately, independent of Clk)
Sin  input  1  serial data bit
SinValid  input  1  Sin is valid this cycle
Start  input  1  qualified by SinValid: this bit is the first bit of a new frame
Dir  input  1  0 = shift-left order (first bit -> MSB), 1 = shift-right order (first bit -> LSB); sampled only on the Start bit
DOut  output  WIDTH  assembled word
DValid  output  1  DOut holds an unconsumed word
DReady  input  1  consumer accepts DOut when DValid=1
Overrun  output  1  one-cycle pulse: completed word dropped because buffer was full
ParErr  output  1  parity error flag (see Optional Feature)

Behaviour:
- Reset (Rst=0): state IDLE; bit count=0; shift register=0; DOut=0; DValid=0; Overrun=0; ParErr=0; latched Dir=0.
- A bit is accepted on a rising edge when SinValid=1.
- FSM states:
  - IDLE: accepted bits with Start=0 are ignored. An accepted bit with Start=1 latches Dir, shifts the bit in, sets count=1, goes to SHIFT.
  - SHIFT: each accepted bit shifts in and increments count.
    - Start=1 in SHIFT discards the partial frame and restarts: the bit is the new first bit, Dir is re-latched, count=1. No output and no error are produced.
    - When the accepted bit makes count equal to the frame length (WIDTH, or WIDTH+1 with parity), the frame completes: return to IDLE, count=0.
- Shift rules:
  - Dir=0: reg <= {reg[WIDTH-2:0], Sin}.
  - Dir=1: reg <= {Sin, reg[WIDTH-1:1]}.
  - No rotate and no hold beyond ignoring cycles with SinValid=0.
- Completion, on the same edge as the last bit:
  - If DValid=0, or DValid=1 with DReady=1: DOut <= assembled word, DValid=1 on the next cycle. Latency is 0 cycles from the last-bit edge to DValid visible.
  - If DValid=1 and DReady=0: the new word is dropped, DOut is unchanged, and Overrun=1 for exactly one cycle.
- Handshake:
  - DValid clears on the edge where DValid=1 and DReady=1, unless a frame completes on that same edge, in which case DValid stays 1 with the new word.
  - DOut is stable while DValid=1 and DReady=0.
- A frame may complete with one-cycle gaps (SinValid=0) between bits. Gaps never abort a frame.
- Reset mid-frame or with DValid=1 discards everything and returns to the reset values.
- DReady while DValid=0 has no effect.

Optional Feature:
Macro PARITY_CHK_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit. The parity bit is not shifted into the word.
  - On completion, ParErr is set if the XOR of the data bits and the parity bit is 1.
  - ParErr is updated only on a completion that loads DOut and holds until the next loaded completion.
  - On Overrun, ParErr is unchanged.
- Not defined: the frame is WIDTH bits, and ParErr is tied to 0.

Test Plan:
- Reset/idle: Rst=0 async pulse mid-cycle -> all outputs 0 immediately. Then SinValid=1 bits with Start=0 -> DValid stays 0.
- Shift-left: Dir=0, Start on first, bits 1,0,0,1, DReady=1 -> DOut=4'b1001, DValid=1 for 1 cycle right after the 4th bit edge. Repeat with 1,1,1,1 -> 4'b1111.
- Shift-right: Dir=1, bits 1,1,0,0 -> DOut=4'b0011. Bits 0,0,0,0 with SinValid gaps of 1 cycle -> DOut=4'b0000.
- Restart: Dir=0, bits 1,1 then Start=1 with bits 0,1,1,0 -> DOut=4'b0110, no Overrun.
- Backpressure: DReady=0, frame 1001 then frame 1100 -> DOut stays 4'b1001, Overrun pulses once. Assert DReady on the same edge a third frame 0011 completes -> DOut=4'b0011, DValid continuously 1.
- PARITY_CHK_EN: frame 1,0,1,1 with parity bit 1 -> DOut=4'b1011, ParErr=0. Same data with parity bit 0 -> ParErr=1.
